// File: rtl/oven_ctrl_mz_if.sv
// oven_ctrl_mz_if: control, sensor and status bundle for the multi-zone oven
// controller. The master side (sequencer / front panel) drives the commands,
// setpoint and ADC samples; the slave side (the controller) returns the
// heater enables and the display status.
interface oven_ctrl_mz_if #(
    parameter int ZONES   = 2,
    parameter int ADC_W   = 12,
    parameter int TEMP_W  = 8,
    parameter int TIMER_W = 4
);
    logic                     start;
    logic                     stop;
    logic [ZONES*ADC_W-1:0]   adc;
    logic [TEMP_W-1:0]        set_temp;
    logic [TIMER_W-1:0]       set_timer;
    logic [ZONES-1:0]         heater;
    logic [4:0]               led;
    logic [TIMER_W-1:0]       remaining;
    logic                     done;

    modport master (
        output start, stop, adc, set_temp, set_timer,
        input  heater, led, remaining, done
    );

    modport slave (
        input  start, stop, adc, set_temp, set_timer,
        output heater, led, remaining, done
    );
endinterface

// File: rtl/oven_ctrl_mz.sv
// oven_ctrl_mz: multi-zone oven controller. Every zone has its own ADC channel
// and hysteresis heater; all zones share one setpoint, one bake timer and one
// IDLE/PREHEAT/BAKE/DONE/FAULT state machine.
// Optional feature: define OVEN_WATCHDOG_EN to fault a preheat that has not
// reached temperature within PREHEAT_MAX ticks.
module oven_ctrl_mz #(
    parameter int ZONES        = 2,
    parameter int ADC_W        = 12,
    parameter int TEMP_W       = 8,
    parameter int TIMER_W      = 4,
    parameter int TICK_DIV     = 50000000,
    parameter int HYST         = 2,
    parameter int FAULT_MARGIN = 20,
    parameter int PREHEAT_MAX  = 600
) (
    input  logic          clk,
    input  logic          rst,
    oven_ctrl_mz_if.slave bus
);
    localparam int SHIFT   = ADC_W - TEMP_W;
    localparam int LO_W    = TEMP_W + 1;
    localparam int SUM_W   = TEMP_W + 2;
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [LO_W-1:0]    HYST_V     = LO_W'(HYST);
    localparam logic [SUM_W-1:0]   MARGIN_V   = SUM_W'(FAULT_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREHEAT,
        S_BAKE,
        S_DONE,
        S_FAULT
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [TEMP_W-1:0]   r_sp;
    logic [TIMER_W-1:0]  r_remaining;
    logic [PRESC_W-1:0]  r_presc;
    logic [ZONES-1:0]    r_heater;
    logic [ZONES-1:0]    w_heaterNext;
    logic                r_done;
    logic [TEMP_W-1:0]   w_sp;
    logic [LO_W-1:0]     w_lo;
    logic [LO_W-1:0]     w_hi;
    logic [SUM_W-1:0]    w_hiSum;
    logic [TEMP_W-1:0]   w_temp [ZONES];
    logic                w_allWarm;
    logic                w_overTemp;
    logic                w_openSensor;
    logic                w_fault;
    logic                w_latch;
    logic                w_tick;
    logic                w_presCount;
    logic                w_wdFault;
    logic [4:0]          w_led;

    // A new cycle is accepted from IDLE or DONE only with a non-zero duration
    // and no simultaneous stop; the setpoint used this cycle is the one about
    // to be latched, so heaters react on the very edge that starts preheat.
    assign w_latch = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start &&
                     !bus.stop && (bus.set_timer != '0);
    assign w_sp    = w_latch ? bus.set_temp : r_sp;

    // Thresholds are one bit wider than the temperature so the band never wraps.
    assign w_lo    = ({1'b0, w_sp} < HYST_V) ? '0 : ({1'b0, w_sp} - HYST_V);
    assign w_hiSum = {2'b00, w_sp} + MARGIN_V;
    assign w_hi    = w_hiSum[SUM_W-1] ? '1 : w_hiSum[LO_W-1:0];
    assign w_fault = w_overTemp | w_openSensor;
    assign w_tick  = (r_presc == PRESC_LAST);

    // Per-zone temperature extraction and the aggregate warm/fault conditions.
    always_comb begin
        w_allWarm    = 1'b1;
        w_overTemp   = 1'b0;
        w_openSensor = 1'b0;
        for (int z = 0; z < ZONES; z++) begin
            w_temp[z] = bus.adc[z*ADC_W + SHIFT +: TEMP_W];
            if ({1'b0, w_temp[z]} < w_lo)    w_allWarm    = 1'b0;
            if ({1'b0, w_temp[z]} > w_hi)    w_overTemp   = 1'b1;
            if (&bus.adc[z*ADC_W +: ADC_W])  w_openSensor = 1'b1;
        end
    end

`ifdef OVEN_WATCHDOG_EN
    localparam int WD_W = (PREHEAT_MAX > 1) ? $clog2(PREHEAT_MAX) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(PREHEAT_MAX - 1);

    logic [WD_W-1:0] r_wdTicks;

    assign w_wdFault   = (r_state == S_PREHEAT) && w_tick && (r_wdTicks == WD_LAST);
    assign w_presCount = ((r_state == S_BAKE) && (w_nextState == S_BAKE)) ||
                         ((r_state == S_PREHEAT) && (w_nextState == S_PREHEAT));

    // Counts whole ticks spent waiting in PREHEAT; any state change clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdTicks <= '0;
        end else if ((r_state == S_PREHEAT) && (w_nextState == S_PREHEAT)) begin
            if (w_tick) r_wdTicks <= r_wdTicks + 1'b1;
        end else begin
            r_wdTicks <= '0;
        end
    end
`else
    assign w_wdFault   = 1'b0;
    assign w_presCount = (r_state == S_BAKE) && (w_nextState == S_BAKE);
`endif

    // Next-state decision; stop beats fault, fault beats timer/threshold.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_latch) w_nextState = S_PREHEAT;
            end
            S_PREHEAT: begin
                if (bus.stop)                   w_nextState = S_IDLE;
                else if (w_fault || w_wdFault)  w_nextState = S_FAULT;
                else if (w_allWarm)             w_nextState = S_BAKE;
            end
            S_BAKE: begin
                if (bus.stop)                                     w_nextState = S_IDLE;
                else if (w_fault)                                 w_nextState = S_FAULT;
                else if (w_tick && (r_remaining == TIMER_W'(1)))  w_nextState = S_DONE;
            end
            S_DONE: begin
                if (bus.stop)     w_nextState = S_IDLE;
                else if (w_latch) w_nextState = S_PREHEAT;
            end
            S_FAULT: begin
                if (bus.stop) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Hysteresis heater drive for the state being entered; off outside heating.
    always_comb begin
        w_heaterNext = '0;
        if ((w_nextState == S_PREHEAT) || (w_nextState == S_BAKE)) begin
            for (int z = 0; z < ZONES; z++) begin
                if ({1'b0, w_temp[z]} < w_lo) w_heaterNext[z] = 1'b1;
                else if (w_temp[z] >= w_sp)   w_heaterNext[z] = 1'b0;
                else                          w_heaterNext[z] = r_heater[z];
            end
        end
    end

    // One-hot status for the display multiplexer.
    always_comb begin
        w_led = 5'b00001;
        case (r_state)
            S_IDLE:    w_led = 5'b00001;
            S_PREHEAT: w_led = 5'b00010;
            S_BAKE:    w_led = 5'b00100;
            S_DONE:    w_led = 5'b01000;
            S_FAULT:   w_led = 5'b10000;
            default:   w_led = 5'b00001;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    // Setpoint/duration latches, bake countdown, prescaler, heaters and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp        <= '0;
            r_remaining <= '0;
            r_presc     <= '0;
            r_heater    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_heater <= w_heaterNext;
            r_done   <= (r_state == S_BAKE) && (w_nextState == S_DONE);
            r_presc  <= (w_presCount && !w_tick) ? r_presc + 1'b1 : '0;
            if (w_latch) begin
                r_sp        <= bus.set_temp;
                r_remaining <= bus.set_timer;
            end else if (((r_state == S_PREHEAT) || (r_state == S_BAKE)) &&
                         (w_nextState == S_IDLE)) begin
                r_remaining <= '0;
            end else if ((r_state == S_BAKE) && w_tick &&
                         ((w_nextState == S_BAKE) || (w_nextState == S_DONE))) begin
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    assign bus.heater    = r_heater;
    assign bus.led       = w_led;
    assign bus.remaining = r_remaining;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_oven_ctrl_mz.sv
// tb_oven_ctrl_mz: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a rule-level model.
module tb_oven_ctrl_mz;
    localparam int ZONES        = 2;
    localparam int ADC_W        = 12;
    localparam int TEMP_W       = 8;
    localparam int TIMER_W      = 4;
    localparam int TICK_DIV     = 4;
    localparam int HYST         = 2;
    localparam int FAULT_MARGIN = 20;
    localparam int PREHEAT_MAX  = 3;

    localparam int ST_IDLE    = 0;
    localparam int ST_PREHEAT = 1;
    localparam int ST_BAKE    = 2;
    localparam int ST_DONE    = 3;
    localparam int ST_FAULT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Model state: position of the lit led bit, latched setpoint, ticks left,
    // cycles spent in the current heating phase, heater and done expectations.
    int               mState = ST_IDLE;
    int               mSp    = 0;
    int               mRem   = 0;
    int               mPhase = 0;
    logic [ZONES-1:0] mHeat  = '0;
    logic             mDone  = 1'b0;

    oven_ctrl_mz_if #(.ZONES(ZONES), .ADC_W(ADC_W), .TEMP_W(TEMP_W), .TIMER_W(TIMER_W)) bus ();

    oven_ctrl_mz #(
        .ZONES(ZONES), .ADC_W(ADC_W), .TEMP_W(TEMP_W), .TIMER_W(TIMER_W),
        .TICK_DIV(TICK_DIV), .HYST(HYST), .FAULT_MARGIN(FAULT_MARGIN),
        .PREHEAT_MAX(PREHEAT_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic stp, input int a0, input int a1,
                                 input int sp, input int tm);
        bus.start     = st;
        bus.stop      = stp;
        bus.adc       = {12'(a1), 12'(a0)};
        bus.set_temp  = 8'(sp);
        bus.set_timer = 4'(tm);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int genAdc(input int sp);
        int r;
        int t;
        r = int'($urandom_range(0, 999));
        if (r < 2) return 4095;
        if (r < 5) t = sp + 21 + int'($urandom_range(0, 9));
        else       t = sp - 8 + int'($urandom_range(0, 11));
        if (t > 255) t = 255;
        if (t < 0)   t = 0;
        return t * 16 + int'($urandom_range(0, 15));
    endfunction

    // Rule-level reference: one call per rising edge with the inputs seen there.
    task automatic modelStep();
        int  t [ZONES];
        int  lo, hi, loNext, next, sp;
        bit  anyFault, allWarm, startOk, wd, tick;
        lo = mSp - HYST;
        if (lo < 0) lo = 0;
        hi = mSp + FAULT_MARGIN;
        if (hi > 511) hi = 511;
        anyFault = 0;
        allWarm  = 1;
        for (int z = 0; z < ZONES; z++) begin
            t[z] = int'(bus.adc[z*ADC_W +: ADC_W]) / (1 << (ADC_W - TEMP_W));
            if (t[z] > hi || int'(bus.adc[z*ADC_W +: ADC_W]) == 4095) anyFault = 1;
            if (t[z] < lo) allWarm = 0;
        end
        startOk = bus.start && !bus.stop && (bus.set_timer != 0);
        next  = mState;
        sp    = mSp;
        mDone = 1'b0;
        case (mState)
            ST_IDLE, ST_DONE: begin
                if (bus.stop) next = ST_IDLE;
                else if (startOk) begin
                    next   = ST_PREHEAT;
                    sp     = int'(bus.set_temp);
                    mRem   = int'(bus.set_timer);
                    mPhase = 0;
                end
            end
            ST_PREHEAT: begin
                wd = 0;
`ifdef OVEN_WATCHDOG_EN
                wd = (mPhase + 1 >= PREHEAT_MAX * TICK_DIV);
`endif
                if (bus.stop) begin
                    next = ST_IDLE;
                    mRem = 0;
                end else if (anyFault || wd) next = ST_FAULT;
                else if (allWarm) begin
                    next   = ST_BAKE;
                    mPhase = 0;
                end else mPhase++;
            end
            ST_BAKE: begin
                tick = ((mPhase % TICK_DIV) == TICK_DIV - 1);
                if (bus.stop) begin
                    next = ST_IDLE;
                    mRem = 0;
                end else if (anyFault) next = ST_FAULT;
                else begin
                    if (tick) begin
                        mRem--;
                        if (mRem == 0) begin
                            next  = ST_DONE;
                            mDone = 1'b1;
                        end
                    end
                    mPhase++;
                end
            end
            default: begin
                if (bus.stop) next = ST_IDLE;
            end
        endcase
        if (next == ST_PREHEAT || next == ST_BAKE) begin
            loNext = sp - HYST;
            if (loNext < 0) loNext = 0;
            for (int z = 0; z < ZONES; z++) begin
                if (t[z] < loNext)  mHeat[z] = 1'b1;
                else if (t[z] >= sp) mHeat[z] = 1'b0;
            end
        end else begin
            mHeat = '0;
        end
        mState = next;
        mSp    = sp;
    endtask

    // Model update process, including asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mState = ST_IDLE;
                mSp    = 0;
                mRem   = 0;
                mPhase = 0;
                mHeat  = '0;
                mDone  = 1'b0;
            end else begin
                modelStep();
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("modelLed", bus.led, 32'(1 << mState));
            checkOutput("modelHeater", bus.heater, mHeat);
            checkOutput("modelRemaining", bus.remaining, mRem);
            checkOutput("modelDone", bus.done, mDone);
        end
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        int n;
        bit found;
        int curTemp;
        applyStimulus(0, 0, 2025, 2400, 150, 13);
        step();
        step();
        rst = 1'b0;
        checkOutput("resetLed", bus.led, 5'b00001);
        checkOutput("resetHeater", bus.heater, 2'b00);
        checkOutput("resetRemaining", bus.remaining, 0);
        checkOutput("resetDone", bus.done, 0);

        $display("[TB] preheat and bake");
        applyStimulus(1, 0, 2025, 2400, 150, 13);
        step();
        checkOutput("preheatLed", bus.led, 5'b00010);
        checkOutput("preheatHeater", bus.heater, 2'b01);
        checkOutput("preheatRemaining", bus.remaining, 13);
        applyStimulus(0, 0, 2368, 2400, 150, 13);
        step();
        checkOutput("bakeLed", bus.led, 5'b00100);
        checkOutput("bakeHeaterHold", bus.heater, 2'b01);
        n = 0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            n++;
            if (n == 4) checkOutput("bakeRemainingAfterTick", bus.remaining, 12);
            if (bus.done) found = 1;
        end
        checkOutput("bakeLength", n, 52);
        checkOutput("doneLed", bus.led, 5'b01000);
        checkOutput("doneHeater", bus.heater, 2'b00);
        checkOutput("doneRemaining", bus.remaining, 0);
        step();
        checkOutput("donePulseWidth", bus.done, 0);
        checkOutput("doneHeld", bus.led, 5'b01000);

        $display("[TB] over-temperature fault");
        applyStimulus(0, 1, 2368, 2400, 150, 13);
        step();
        checkOutput("doneStopLed", bus.led, 5'b00001);
        applyStimulus(1, 0, 2368, 2400, 150, 13);
        step();
        applyStimulus(0, 0, 2368, 2400, 150, 13);
        step();
        checkOutput("rebakeLed", bus.led, 5'b00100);
        applyStimulus(0, 0, 2368, 2800, 150, 13);
        step();
        checkOutput("overTempLed", bus.led, 5'b10000);
        checkOutput("overTempHeater", bus.heater, 2'b00);
        checkOutput("faultRemainingHeld", bus.remaining, 13);
        applyStimulus(1, 0, 2368, 2800, 150, 5);
        step();
        checkOutput("faultIgnoresStart", bus.led, 5'b10000);
        applyStimulus(0, 1, 2368, 2400, 150, 5);
        step();
        checkOutput("faultStopLed", bus.led, 5'b00001);

        $display("[TB] ignored starts");
        applyStimulus(1, 0, 2368, 2400, 150, 0);
        step();
        checkOutput("zeroTimerStart", bus.led, 5'b00001);
        applyStimulus(1, 1, 2368, 2400, 150, 5);
        step();
        checkOutput("startWithStop", bus.led, 5'b00001);

        $display("[TB] open sensor and async reset");
        applyStimulus(1, 0, 2025, 2400, 150, 5);
        step();
        checkOutput("openPreheatLed", bus.led, 5'b00010);
        applyStimulus(0, 0, 4095, 2400, 150, 5);
        step();
        checkOutput("openSensorLed", bus.led, 5'b10000);
        checkOutput("openSensorHeater", bus.heater, 2'b00);
        applyStimulus(0, 1, 2368, 2400, 150, 5);
        step();
        applyStimulus(1, 0, 2368, 2400, 150, 9);
        step();
        applyStimulus(0, 0, 2368, 2400, 150, 9);
        step();
        checkOutput("resetBakeLed", bus.led, 5'b00100);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncResetLed", bus.led, 5'b00001);
        checkOutput("asyncResetRemaining", bus.remaining, 0);
        checkOutput("asyncResetHeater", bus.heater, 2'b00);
        step();
        rst = 1'b0;

        $display("[TB] preheat time limit");
        applyStimulus(1, 0, 2025, 2400, 150, 5);
        step();
        applyStimulus(0, 0, 2025, 2400, 150, 5);
`ifdef OVEN_WATCHDOG_EN
        n = 0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            n++;
            if (bus.led == 5'b10000) found = 1;
        end
        checkOutput("watchdogCycles", n, 12);
`else
        for (int c = 0; c < 40; c++) step();
        checkOutput("preheatNoLimit", bus.led, 5'b00010);
`endif
        applyStimulus(0, 1, 2025, 2400, 150, 5);
        step();

        $display("[TB] random traffic");
        curTemp = 150;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 99) < 3) curTemp = int'($urandom_range(20, 220));
            applyStimulus(($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 2),
                          genAdc(curTemp), genAdc(curTemp), curTemp,
                          int'($urandom_range(1, 6)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
